// File: rtl/arith_unit_seq_if.sv
// Operand/request and result/status bundle between the switch/button front end and arith_unit_seq.
// The master side drives the requests and the slave side (the unit) returns the results.
interface arith_unit_seq_if #(
    parameter int WIDTH = 4
);
    logic             enable;
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] input_a;
    logic [WIDTH-1:0] input_b;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] led;

    modport master (
        output enable, start, op, input_a, input_b,
        input  result, carry, busy, done, led
    );

    modport slave (
        input  enable, start, op, input_a, input_b,
        output result, carry, busy, done, led
    );
endinterface

// File: rtl/arith_unit_seq.sv
// Registered add/sub/accumulate/shift-add multiply unit feeding the LED bank.
// Latency: add/sub/acc done 1 cycle after start; multiply done WIDTH+1 cycles after start.
// Backpressure: none; start is ignored while busy or disabled, never queued.
module arith_unit_seq #(
    parameter int WIDTH = 4
) (
    input logic          clk,
    input logic          rst,
    arith_unit_seq_if.slave bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic {
        IDLE,
        MUL
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   result_q;
    logic               carry_q;
    logic               busy_q;
    logic               done_q;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] addend;
    logic [2*WIDTH-1:0] prod_nxt;
    logic [WIDTH:0]     sum;

    // One extra bit on the single-cycle ops: it is carry-out for add/acc and borrow for sub.
    always_comb begin
        sum = '0;
        case (bus.op)
            2'b00:   sum = {1'b0, bus.input_a} + {1'b0, bus.input_b};
            2'b01:   sum = {1'b0, bus.input_a} - {1'b0, bus.input_b};
            2'b11:   sum = {1'b0, result_q} + {1'b0, bus.input_a};
            default: sum = '0;
        endcase
    end

    always_comb begin
        addend   = '0;
        if (b_q[cnt]) begin
            addend = {{WIDTH{1'b0}}, a_q} << cnt;
        end
        prod_nxt = prod + addend;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cnt      <= '0;
            prod     <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.enable && bus.start) begin
                        if (bus.op == 2'b10) begin
                            a_q    <= bus.input_a;
                            b_q    <= bus.input_b;
                            prod   <= '0;
                            cnt    <= '0;
                            busy_q <= 1'b1;
                            state  <= MUL;
                        end else begin
                            result_q <= sum[WIDTH-1:0];
                            carry_q  <= sum[WIDTH];
                            done_q   <= 1'b1;
                        end
                    end
                end
                MUL: begin
                    if (!bus.enable) begin
                        // Abort: result/carry keep their pre-multiply values.
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        prod <= prod_nxt;
                        cnt  <= cnt + 1'b1;
                        if (cnt == CW'(WIDTH - 1)) begin
                            result_q <= prod_nxt[WIDTH-1:0];
                            carry_q  <= |prod_nxt[2*WIDTH-1:WIDTH];
                            done_q   <= 1'b1;
                            busy_q   <= 1'b0;
                            state    <= IDLE;
                        end
                    end
                end
                default: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.result = result_q;
    assign bus.carry  = carry_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.led    = bus.enable ? result_q : '1;
endmodule

// File: tb/tb_arith_unit_seq.sv
// Directed-vector bench for arith_unit_seq at WIDTH=4 with hand-computed expectations.
module tb_arith_unit_seq;
    localparam int WIDTH = 4;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    arith_unit_seq_if #(.WIDTH(WIDTH)) bus ();

    arith_unit_seq #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
        bus.op      = op;
        bus.input_a = a;
        bus.input_b = b;
        bus.start   = 1'b1;
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        rst         = 1'b1;
        bus.enable  = 1'b1;
        bus.start   = 1'b0;
        bus.op      = 2'b00;
        bus.input_a = '0;
        bus.input_b = '0;

        // Reset state
        tick();
        tick();
        rst = 1'b0;
        chk("rst_result", 32'(bus.result), 32'h0);
        chk("rst_carry",  32'(bus.carry),  32'h0);
        chk("rst_busy",   32'(bus.busy),   32'h0);
        chk("rst_done",   32'(bus.done),   32'h0);
        chk("rst_led",    32'(bus.led),    32'h0);
        bus.enable = 1'b0;
        #1;
        chk("rst_led_dis", 32'(bus.led), 32'hF);
        bus.enable = 1'b1;
        tick();
        chk("post_rst_done", 32'(bus.done), 32'h0);

        // Add 9+8 = 17 -> 0x1 carry 1
        req(2'b00, 4'd9, 4'd8);
        tick();
        bus.start = 1'b0;
        chk("add_result", 32'(bus.result), 32'h1);
        chk("add_carry",  32'(bus.carry),  32'h1);
        chk("add_done",   32'(bus.done),   32'h1);
        chk("add_led",    32'(bus.led),    32'h1);
        tick();
        chk("add_done_clr", 32'(bus.done), 32'h0);

        // Sub 3-5 -> 0xE borrow; 5-3 -> 0x2 no borrow
        req(2'b01, 4'd3, 4'd5);
        tick();
        chk("sub35_result", 32'(bus.result), 32'hE);
        chk("sub35_carry",  32'(bus.carry),  32'h1);
        req(2'b01, 4'd5, 4'd3);
        tick();
        bus.start = 1'b0;
        chk("sub53_result", 32'(bus.result), 32'h2);
        chk("sub53_carry",  32'(bus.carry),  32'h0);
        chk("sub53_done",   32'(bus.done),   32'h1);
        tick();
        chk("sub_done_clr", 32'(bus.done), 32'h0);

        // Mul 3*5 = 15; operands changed and start pulsed during busy
        req(2'b10, 4'd3, 4'd5);
        tick();
        chk("mul1_busy0", 32'(bus.busy),   32'h1);
        chk("mul1_done0", 32'(bus.done),   32'h0);
        chk("mul1_hold",  32'(bus.result), 32'h2);
        req(2'b00, 4'hF, 4'hF);
        for (int i = 1; i < 4; i++) begin
            tick();
            bus.start = 1'b0;
            chk($sformatf("mul1_busy%0d", i), 32'(bus.busy), 32'h1);
            chk($sformatf("mul1_done%0d", i), 32'(bus.done), 32'h0);
        end
        tick();
        chk("mul1_result", 32'(bus.result), 32'hF);
        chk("mul1_carry",  32'(bus.carry),  32'h0);
        chk("mul1_done",   32'(bus.done),   32'h1);
        chk("mul1_busy",   32'(bus.busy),   32'h0);
        tick();
        chk("mul1_done_clr", 32'(bus.done),   32'h0);
        chk("mul1_ignored",  32'(bus.result), 32'hF);

        // Mul 6*5 = 30 = 0x1E -> 0xE carry 1
        req(2'b10, 4'd6, 4'd5);
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        tick();
        chk("mul2_done_early", 32'(bus.done), 32'h0);
        tick();
        chk("mul2_result", 32'(bus.result), 32'hE);
        chk("mul2_carry",  32'(bus.carry),  32'h1);
        chk("mul2_done",   32'(bus.done),   32'h1);

        // Accumulate 7 three times from reset: 7, 14, 21 -> 0x7, 0xE, 0x5 c1
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req(2'b11, 4'd7, 4'd0);
        tick();
        chk("acc1_result", 32'(bus.result), 32'h7);
        chk("acc1_carry",  32'(bus.carry),  32'h0);
        tick();
        chk("acc2_result", 32'(bus.result), 32'hE);
        chk("acc2_carry",  32'(bus.carry),  32'h0);
        tick();
        bus.start = 1'b0;
        chk("acc3_result", 32'(bus.result), 32'h5);
        chk("acc3_carry",  32'(bus.carry),  32'h1);
        tick();

        // Mul 6*5 aborted by enable drop on 2nd busy cycle
        req(2'b10, 4'd6, 4'd5);
        tick();
        bus.start = 1'b0;
        chk("abort_busy1", 32'(bus.busy), 32'h1);
        tick();
        chk("abort_busy2", 32'(bus.busy), 32'h1);
        bus.enable = 1'b0;
        #1;
        chk("abort_led", 32'(bus.led), 32'hF);
        tick();
        chk("abort_busy",   32'(bus.busy),   32'h0);
        chk("abort_done",   32'(bus.done),   32'h0);
        chk("abort_result", 32'(bus.result), 32'h5);
        chk("abort_carry",  32'(bus.carry),  32'h1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("abort_nodone%0d", i), 32'(bus.done), 32'h0);
        end
        req(2'b00, 4'd1, 4'd1);
        tick();
        bus.start = 1'b0;
        chk("dis_start_done",   32'(bus.done),   32'h0);
        chk("dis_start_result", 32'(bus.result), 32'h5);
        bus.enable = 1'b1;
        #1;
        chk("reenable_led", 32'(bus.led), 32'h5);
        tick();

        // Reset mid-multiply, then a fresh add 1+1
        req(2'b10, 4'd3, 4'd5);
        tick();
        bus.start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_result", 32'(bus.result), 32'h0);
        chk("mrst_carry",  32'(bus.carry),  32'h0);
        chk("mrst_busy",   32'(bus.busy),   32'h0);
        chk("mrst_done",   32'(bus.done),   32'h0);
        tick();
        chk("mrst_done_after", 32'(bus.done), 32'h0);
        chk("mrst_led",        32'(bus.led),  32'h0);
        req(2'b00, 4'd1, 4'd1);
        tick();
        bus.start = 1'b0;
        chk("fresh_add_result", 32'(bus.result), 32'h2);
        chk("fresh_add_carry",  32'(bus.carry),  32'h0);
        chk("fresh_add_done",   32'(bus.done),   32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
